// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolutor host-side driver.
//   drv_state_t      : driver FSM states (3-bit encoding)
//   CONV_OPW         : operand width of the convolutor core
//   CONV_RESW        : result width of the convolutor core
//   CONV_MIN_LATENCY : cycles the core needs after reset release before io_out is valid
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    RUN  = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } drv_state_t;

  localparam int CONV_OPW         = 6;
  localparam int CONV_RESW        = 4;
  localparam int CONV_MIN_LATENCY = 7;

endpackage

// File: rtl/conv_drv_timer.sv
// conv_drv_timer: cycle counter with a loadable terminal compare.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : force the count to zero (wins over en)
//   en         : advance the count by one this cycle
//   term       : terminal value to compare against
//   done       : count equals term
module conv_drv_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign done = (count_reg == term);

endmodule

// File: rtl/conv_driver.sv
// conv_driver: host-side initiator for the bit-serial convolutor core.
//   clk, reset          : clock, asynchronous active-high reset
//   op_valid/op_ready   : operand pair handshake, op_a -> core bits [OPW-1:0],
//                         op_b -> core bits [2*OPW-1:OPW]
//   res_valid/res_ready : result handshake, res_data holds the captured core result
//   core_io_in          : operands to the core, held for the whole operation
//   core_reset          : core reset, high whenever the core is not computing
//   core_io_out         : core result input
//   busy                : high in any state other than IDLE
//   op_count            : completed operations, wraps 255 -> 0
module conv_driver
  import conv_pkg::*;
#(
  parameter int OPW        = CONV_OPW,
  parameter int RESW       = CONV_RESW,
  parameter int RST_CYCLES = 2,
  parameter int LATENCY    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OPW-1:0]    op_a,
  input  logic [OPW-1:0]    op_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RESW-1:0]   res_data,
  output logic [2*OPW-1:0]  core_io_in,
  output logic              core_reset,
  input  logic [RESW-1:0]   core_io_out,
  output logic              busy,
  output logic [7:0]        op_count
);

  // One extra bit so the larger terminal value never wraps the counter.
  localparam int CW = $clog2(LATENCY + RST_CYCLES) + 1;
  localparam logic [CW-1:0] RST_TERM = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LAT_TERM = CW'(LATENCY - 1);

  drv_state_t state_reg, state_next;

  logic            timer_clear;
  logic            timer_en;
  logic            timer_done;
  logic [CW-1:0]   timer_term;

  logic [2*OPW-1:0] core_io_in_reg;
  logic [RESW-1:0]  res_data_reg;
  logic             res_valid_reg;
  logic [7:0]       op_count_reg;
  logic             core_reset_reg;
  logic             busy_reg;

  // The same timer measures both the reset hold and the compute wait;
  // only the terminal value changes with the state.
  conv_drv_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (timer_clear),
    .en    (timer_en),
    .term  (timer_term),
    .done  (timer_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    timer_term  = (state_reg == RST) ? RST_TERM : LAT_TERM;
    case (state_reg)
      IDLE: begin
        if (op_valid) begin
          state_next  = RST;
          timer_clear = 1'b1;
        end
      end
      RST: begin
        if (timer_done) begin
          state_next  = RUN;
          timer_clear = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      RUN: begin
        if (timer_done) begin
          state_next = CAP;
        end else begin
          timer_en = 1'b1;
        end
      end
      CAP: begin
        state_next = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // core_reset and busy are registered from the next state so they line up
  // exactly with the state they describe without any input-to-output path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_io_in_reg <= '0;
      res_data_reg   <= '0;
      res_valid_reg  <= 1'b0;
      op_count_reg   <= 8'd0;
      core_reset_reg <= 1'b1;
      busy_reg       <= 1'b0;
    end else begin
      core_reset_reg <= (state_next != RUN);
      busy_reg       <= (state_next != IDLE);
      if (state_reg == IDLE && op_valid) begin
        core_io_in_reg <= {op_b, op_a};
      end
      if (state_reg == CAP) begin
        res_data_reg  <= core_io_out;
        res_valid_reg <= 1'b1;
        op_count_reg  <= op_count_reg + 8'd1;
      end else if (state_reg == RESP && res_ready) begin
        res_valid_reg <= 1'b0;
      end
    end
  end

  assign op_ready   = (state_reg == IDLE);
  assign res_valid  = res_valid_reg;
  assign res_data   = res_data_reg;
  assign core_io_in = core_io_in_reg;
  assign core_reset = core_reset_reg;
  assign busy       = busy_reg;
  assign op_count   = op_count_reg;

endmodule

// File: tb/tb_conv_driver.sv
// tb_conv_driver: self-checking bench for conv_driver.
// A behavioural core stub answers popcount({op_b,op_a})/2 once it has been out
// of reset for at least CONV_MIN_LATENCY cycles and 4'h9 otherwise, so an early
// or late capture shows up as a wrong result or a wrong latency.
module tb_conv_driver;
  import conv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid, op_ready;
  logic [5:0]  op_a, op_b;
  logic        res_valid, res_ready;
  logic [3:0]  res_data;
  logic [11:0] core_io_in;
  logic        core_reset;
  logic [3:0]  core_io_out;
  logic        busy;
  logic [7:0]  op_count;

  // second instance built with the minimum latency
  logic        op_valid7, op_ready7, res_valid7, res_ready7;
  logic [3:0]  res_data7, core_io_out7;
  logic [11:0] core_io_in7;
  logic        core_reset7, busy7;
  logic [7:0]  op_count7;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  int acc_n  = 0;
  int acc_q[$];
  int low_cnt  = 0;
  int low_cnt7 = 0;

  always #5 clk = ~clk;

  conv_driver dut (
    .clk(clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .core_io_in(core_io_in), .core_reset(core_reset), .core_io_out(core_io_out),
    .busy(busy), .op_count(op_count)
  );

  conv_driver #(.LATENCY(7)) dut7 (
    .clk(clk), .reset(reset),
    .op_valid(op_valid7), .op_ready(op_ready7), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid7), .res_ready(res_ready7), .res_data(res_data7),
    .core_io_in(core_io_in7), .core_reset(core_reset7), .core_io_out(core_io_out7),
    .busy(busy7), .op_count(op_count7)
  );

  // reference result of the convolutor for a given core input word
  function automatic logic [3:0] core_fn(input logic [11:0] x);
    int n;
    n = 0;
    for (int i = 0; i < 12; i++) n += int'(x[i]);
    return 4'(n / 2);
  endfunction

  // core stubs: count cycles out of reset
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_reset) low_cnt <= 0; else low_cnt <= low_cnt + 1;
    if (core_reset7) low_cnt7 <= 0; else low_cnt7 <= low_cnt7 + 1;
  end
  assign core_io_out  = (low_cnt  >= CONV_MIN_LATENCY) ? core_fn(core_io_in)  : 4'h9;
  assign core_io_out7 = (low_cnt7 >= CONV_MIN_LATENCY) ? core_fn(core_io_in7) : 4'h9;

  // accept monitor: pre-edge values are visible in the active region at posedge
  always @(posedge clk) begin
    if (!reset && op_valid && op_ready) begin
      acc_n++;
      acc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge right after the accept edge
  task automatic issue(input logic [5:0] a, input logic [5:0] b);
    int n;
    n = 0;
    while (!op_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!op_ready) check("issue_ready_timeout", 32'(op_ready), 32'd1);
    op_a = a;
    op_b = b;
    op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // k = number of negedges after the one following the accept edge
  task automatic wait_result(output int k);
    k = 0;
    while (!res_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] ops [3];
    logic [11:0] v;
    int k, n, base, acc0;
    logic [7:0] cnt0;

    op_valid = 0; op_a = 0; op_b = 0; res_ready = 0;
    op_valid7 = 0; res_ready7 = 1;
    reset = 1;
    repeat (3) @(negedge clk);

    check("rst_op_ready",   32'(op_ready),   32'd1);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_data",   32'(res_data),   32'd0);
    check("rst_core_io_in", 32'(core_io_in), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_op_count",   32'(op_count),   32'd0);
    reset = 0;
    @(negedge clk);

    // first operation, cycle by cycle: reset held 2 cycles, core runs 8, result at 11
    op_a = 6'h3F; op_b = 6'h3F; op_valid = 1;
    @(negedge clk);
    op_valid = 0;
    for (int i = 0; i <= 11; i++) begin
      if (i > 0) @(negedge clk);
      check("op1_core_io_in", 32'(core_io_in), 32'hFFF);
      check("op1_core_reset", 32'(core_reset), (i >= 2 && i <= 9) ? 32'd0 : 32'd1);
      check("op1_res_valid",  32'(res_valid),  (i == 11) ? 32'd1 : 32'd0);
      check("op1_busy",       32'(busy),       32'd1);
      check("op1_op_ready",   32'(op_ready),   32'd0);
    end
    check("op1_res_data", 32'(res_data), 32'h6);
    check("op1_op_count", 32'(op_count), 32'd1);

    // backpressure: stub output has gone back to 4'h9, result must hold
    repeat (20) begin
      @(negedge clk);
      check("bp_res_data",  32'(res_data),  32'h6);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_op_ready",  32'(op_ready),  32'd0);
      check("bp_busy",      32'(busy),      32'd1);
    end
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    check("bp_release_op_ready",  32'(op_ready),  32'd1);
    check("bp_release_res_valid", 32'(res_valid), 32'd0);
    check("bp_release_busy",      32'(busy),      32'd0);

    // back-to-back with res_ready high: the accept-to-accept spacing is
    // RST + RUN + CAP + RESP + one IDLE cycle = 13
    ops[0] = 12'h015; ops[1] = 12'h2AA; ops[2] = 12'hFC0;
    res_ready = 1;
    base = acc_q.size();
    cnt0 = op_count;
    for (int i = 0; i < 3; i++) begin
      v = ops[i];
      issue(v[5:0], v[11:6]);
      wait_result(k);
      check("b2b_latency", 32'(k), 32'd11);
      check("b2b_res_data", 32'(res_data), 32'(core_fn(v)));
    end
    @(negedge clk);
    check("b2b_accepts", 32'(acc_q.size() - base), 32'd3);
    if (acc_q.size() - base == 3) begin
      check("b2b_spacing1", 32'(acc_q[base+1] - acc_q[base]),   32'd13);
      check("b2b_spacing2", 32'(acc_q[base+2] - acc_q[base+1]), 32'd13);
    end
    check("b2b_op_count", 32'(op_count), 32'(8'(cnt0 + 8'd3)));
    res_ready = 0;

    // operand inputs and op_valid thrash while busy
    v = 12'($urandom);
    cnt0 = op_count;
    issue(v[5:0], v[11:6]);
    acc0 = acc_n;
    n = 0;
    while (!res_valid && n < 40) begin
      op_a = 6'($urandom);
      op_b = 6'($urandom);
      op_valid = 1'($urandom);
      @(negedge clk);
      check("tog_core_io_in", 32'(core_io_in), 32'(v));
      n++;
    end
    op_valid = 0;
    check("tog_latency",    32'(n),              32'd11);
    check("tog_no_accept",  32'(acc_n - acc0),   32'd0);
    check("tog_res_data",   32'(res_data),       32'(core_fn(v)));
    check("tog_op_count",   32'(op_count),       32'(8'(cnt0 + 8'd1)));
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;

    // asynchronous reset while the core is running (timer at 4)
    v = 12'($urandom);
    issue(v[5:0], v[11:6]);
    repeat (6) @(negedge clk);
    check("ar_core_reset_before", 32'(core_reset), 32'd0);
    reset = 1;
    #1;
    check("ar_core_reset",  32'(core_reset), 32'd1);
    check("ar_res_valid",   32'(res_valid),  32'd0);
    check("ar_busy",        32'(busy),       32'd0);
    check("ar_op_count",    32'(op_count),   32'd0);
    check("ar_core_io_in",  32'(core_io_in), 32'd0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    check("ar_op_ready", 32'(op_ready), 32'd1);
    n = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_valid) n++;
    end
    check("ar_no_result",       32'(n),        32'd0);
    check("ar_op_count_after",  32'(op_count), 32'd0);

    // 256 operations: op_count wraps back to 0
    for (int i = 0; i < 256; i++) begin
      v = 12'($urandom);
      issue(v[5:0], v[11:6]);
      wait_result(k);
      check("wrap_latency",  32'(k),        32'd11);
      check("wrap_res_data", 32'(res_data), 32'(core_fn(v)));
      if (i == 254) check("wrap_op_count_255", 32'(op_count), 32'd255);
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
    end
    check("wrap_op_count_0", 32'(op_count), 32'd0);

    // minimum-latency build: result 10 cycles after accept
    for (int i = 0; i < 2; i++) begin
      v = 12'($urandom);
      n = 0;
      while (!op_ready7 && n < 40) begin
        @(negedge clk);
        n++;
      end
      op_a = v[5:0];
      op_b = v[11:6];
      op_valid7 = 1;
      @(negedge clk);
      op_valid7 = 0;
      k = 0;
      while (!res_valid7 && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("lat7_latency",  32'(k),         32'd10);
      check("lat7_res_data", 32'(res_data7), 32'(core_fn(v)));
    end
    @(negedge clk);
    check("lat7_op_count", 32'(op_count7), 32'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
